// File: rtl/sram_byte_ctrl.sv
// Byte-wide controller for an external asynchronous SRAM: timed read/write cycles
// driven by one-cycle IO strobes, with an auto-incrementing address pointer.
module sram_byte_ctrl #(
  parameter int AW          = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int AUTOINC     = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_addr_lo,
  input  logic          wr_addr_hi,
  input  logic          wr_data,
  input  logic          rd_start,
  input  logic [15:0]   wd,
  output logic [7:0]    rdata,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          ovr,
  output logic [AW-1:0] sram_a,
  output logic [7:0]    sram_d_out,
  output logic          sram_d_oe,
  input  logic [7:0]    sram_d_in,
  output logic          sram_ncs,
  output logic          sram_nwe,
  output logic          sram_noe
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WAIT_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_STEP = (AUTOINC != 0) ? AW'(1) : '0;

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_PULSE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          pulse_done;
  logic          any_strobe;

  assign pulse_done = (cnt == CNT_LAST);
  assign any_strobe = wr_addr_lo | wr_addr_hi | wr_data | rd_start;
  // The address register is itself the registered pin driver.
  assign sram_a     = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      ovr        <= 1'b0;
      sram_d_out <= '0;
      sram_d_oe  <= 1'b0;
      sram_ncs   <= 1'b1;
      sram_nwe   <= 1'b1;
      sram_noe   <= 1'b1;
    end else begin
      // Strobes during an access are dropped so address and data stay stable.
      if (state != IDLE && any_strobe) ovr <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_addr_lo) begin
            addr[15:0] <= wd;
            ovr        <= 1'b0;
          end
          if (wr_addr_hi) addr[AW-1:16] <= wd[AW-17:0];
          if (wr_data) begin
            sram_d_out <= wd[7:0];
            sram_d_oe  <= 1'b1;
            sram_ncs   <= 1'b0;
            busy       <= 1'b1;
            state      <= WR_SETUP;
            if (rd_start) ovr <= 1'b1;
          end else if (rd_start) begin
            sram_ncs <= 1'b0;
            sram_noe <= 1'b0;
            busy     <= 1'b1;
            state    <= RD_SETUP;
          end
        end
        WR_SETUP: begin
          sram_nwe <= 1'b0;
          cnt      <= '0;
          state    <= WR_PULSE;
        end
        WR_PULSE: begin
          if (pulse_done) begin
            sram_nwe <= 1'b1;
            state    <= WR_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_HOLD: begin
          sram_ncs  <= 1'b1;
          sram_d_oe <= 1'b0;
          busy      <= 1'b0;
          addr      <= addr + ADDR_STEP;
          state     <= IDLE;
        end
        RD_SETUP: begin
          cnt   <= '0;
          state <= RD_PULSE;
        end
        RD_PULSE: begin
          if (pulse_done) begin
            rdata    <= sram_d_in;
            sram_ncs <= 1'b1;
            sram_noe <= 1'b1;
            busy     <= 1'b0;
            addr     <= addr + ADDR_STEP;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Bench for sram_byte_ctrl: directed accesses against a behavioural SRAM, with
// completed accesses checked by a monitor popping an expected-access queue.
module tb_sram_byte_ctrl;

  localparam int AW = 18;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_addr_lo, wr_addr_hi, wr_data, rd_start;
  logic [15:0]   wd;
  logic [7:0]    rdata;
  logic [AW-1:0] addr;
  logic          busy, ovr;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d_out;
  logic          sram_d_oe;
  logic [7:0]    sram_d_in;
  logic          sram_ncs, sram_nwe, sram_noe;

  sram_byte_ctrl #(.AW(AW), .WAIT_CYCLES(W), .AUTOINC(1)) dut (
    .clk(clk), .reset(reset),
    .wr_addr_lo(wr_addr_lo), .wr_addr_hi(wr_addr_hi),
    .wr_data(wr_data), .rd_start(rd_start), .wd(wd),
    .rdata(rdata), .addr(addr), .busy(busy), .ovr(ovr),
    .sram_a(sram_a), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe),
    .sram_d_in(sram_d_in), .sram_ncs(sram_ncs),
    .sram_nwe(sram_nwe), .sram_noe(sram_noe)
  );

  // Clock / reset
  always #10 clk = ~clk;

  // Behavioural SRAM; read data is registered as the top level would do.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk)
    sram_d_in <= (!sram_ncs && !sram_noe) ? mem[sram_a] : 8'h00;
  always @(negedge clk)
    if (!sram_ncs && !sram_nwe) mem[sram_a] = sram_d_out;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Expected access: {is_write, address used, data, address after}
  localparam int EW = 1 + AW + 8 + AW;
  logic [EW-1:0] exp_q[$];

  task automatic push_exp(input logic is_wr, input logic [AW-1:0] a,
                          input logic [7:0] d, input logic [AW-1:0] a_next);
    exp_q.push_back({is_wr, a, d, a_next});
  endtask

  // Monitor: per-cycle pin invariants plus per-access checks when busy falls.
  int            busy_cnt, nwe_cnt, noe_cnt;
  logic          prev_busy, unstable;
  logic [AW-1:0] cap_a;
  logic [7:0]    cap_d;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0; nwe_cnt = 0; noe_cnt = 0;
      prev_busy = 1'b0; unstable = 1'b0;
    end else begin
      check("sram_a_eq_addr", 32'(sram_a), 32'(addr));
      check("nwe_noe_exclusive", 32'(!sram_nwe && !sram_noe), 32'd0);
      check("doe_while_noe", 32'(sram_d_oe && !sram_noe), 32'd0);
      if (busy) begin
        busy_cnt++;
        if (!sram_noe) noe_cnt++;
        if (!sram_nwe) begin
          if (nwe_cnt == 0) begin
            cap_a = sram_a; cap_d = sram_d_out;
          end else if (cap_a !== sram_a || cap_d !== sram_d_out) begin
            unstable = 1'b1;
          end
          nwe_cnt++;
        end
      end
      if (prev_busy && !busy) begin
        check("idle_pins", {28'd0, sram_ncs, sram_nwe, sram_noe, sram_d_oe}, 32'hE);
        if (exp_q.size() == 0) begin
          check("unexpected_access", 32'd1, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("addr_after", 32'(addr), 32'(e[AW-1:0]));
          if (e[EW-1]) begin
            check("wr_busy_cycles", busy_cnt, 2 + W);
            check("wr_nwe_low", nwe_cnt, W);
            check("wr_noe_low", noe_cnt, 0);
            check("wr_stable", 32'(unstable), 32'd0);
            check("wr_addr", 32'(cap_a), 32'(e[EW-2 -: AW]));
            check("wr_data", 32'(cap_d), 32'(e[AW+7 -: 8]));
          end else begin
            check("rd_busy_cycles", busy_cnt, 1 + W);
            check("rd_noe_low", noe_cnt, 1 + W);
            check("rd_nwe_low", nwe_cnt, 0);
            check("rdata", 32'(rdata), 32'(e[AW+7 -: 8]));
          end
        end
        busy_cnt = 0; nwe_cnt = 0; noe_cnt = 0; unstable = 1'b0;
      end
      prev_busy = busy;
    end
  end

  // Driver tasks: called just after a negedge, return at the next negedge.
  task automatic pulse(input logic lo, input logic hi, input logic wr,
                       input logic rd, input logic [15:0] v);
    wr_addr_lo = lo; wr_addr_hi = hi; wr_data = wr; rd_start = rd; wd = v;
    @(negedge clk);
    wr_addr_lo = 0; wr_addr_hi = 0; wr_data = 0; rd_start = 0; wd = 16'h0;
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    pulse(1, 0, 0, 0, a[15:0]);
    pulse(0, 1, 0, 0, 16'(a[AW-1:16]));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1; wr_addr_lo = 0; wr_addr_hi = 0; wr_data = 0; rd_start = 0; wd = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pins", {28'd0, sram_ncs, sram_nwe, sram_noe, sram_d_oe}, 32'hE);
    check("rst_state", {busy, ovr, rdata, sram_d_out}, 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    reset = 0;
    @(negedge clk);

    // Abort a write mid-pulse with ovr set.
    set_addr(18'h00050);
    pulse(0, 0, 1, 0, 16'h0077);
    pulse(0, 0, 0, 1, 16'h0000);
    check("ovr_before_reset", 32'(ovr), 32'd1);
    check("in_wr_pulse", 32'(sram_nwe), 32'd0);
    reset = 1;
    @(negedge clk);
    check("abort_pins", {28'd0, sram_ncs, sram_nwe, sram_noe, sram_d_oe}, 32'hE);
    check("abort_state", {busy, ovr}, 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    reset = 0;
    @(negedge clk);

    // Write 0xA5 at 0x21234.
    pulse(1, 0, 0, 0, 16'h1234);
    pulse(0, 1, 0, 0, 16'h0002);
    check("addr_loaded", 32'(addr), 32'h21234);
    push_exp(1, 18'h21234, 8'hA5, 18'h21235);
    pulse(0, 0, 1, 0, 16'h00A5);
    wait_idle();
    check("mem_21234", 32'(mem[18'h21234]), 32'hA5);

    // Read 0x21234 with the memory returning 0x5A.
    mem[18'h21234] = 8'h5A;
    pulse(1, 0, 0, 0, 16'h1234);
    push_exp(0, 18'h21234, 8'h5A, 18'h21235);
    pulse(0, 0, 0, 1, 16'h0000);
    wait_idle();

    // Pointer wrap from the top address.
    set_addr(18'h3FFFF);
    push_exp(1, 18'h3FFFF, 8'h11, 18'h00000);
    pulse(0, 0, 1, 0, 16'h0011);
    wait_idle();
    check("mem_3ffff", 32'(mem[18'h3FFFF]), 32'h11);

    // Read during a write is dropped; wr_addr_lo clears ovr.
    set_addr(18'h00000);
    push_exp(1, 18'h00000, 8'h22, 18'h00001);
    pulse(0, 0, 1, 0, 16'h0022);
    pulse(0, 0, 0, 1, 16'h0000);
    wait_idle();
    check("ovr_dropped_rd", 32'(ovr), 32'd1);
    pulse(1, 0, 0, 0, 16'h0200);
    check("ovr_cleared", 32'(ovr), 32'd0);
    check("addr_after_clear", 32'(addr), 32'h00200);

    // Simultaneous write and read: write wins.
    set_addr(18'h00100);
    push_exp(1, 18'h00100, 8'h33, 18'h00101);
    pulse(0, 0, 1, 1, 16'h0033);
    wait_idle();
    check("ovr_collision", 32'(ovr), 32'd1);

    // 16 back-to-back writes, each strobed on the cycle busy falls.
    pulse(1, 0, 0, 0, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      push_exp(1, 18'h00100 + 18'(i), 8'(i), 18'h00101 + 18'(i));
      pulse(0, 0, 1, 0, 16'(i));
      wait_idle();
    end
    for (int i = 0; i < 16; i++)
      check("burst_mem", 32'(mem[18'h00100 + 18'(i)]), 32'(i));
    check("ovr_after_burst", 32'(ovr), 32'd0);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
